// File: rtl/mux_rr_arbiter_pkg.sv
// rtl/mux_rr_arbiter_pkg.sv - shared constants, state encoding and index-width helper
// Contents: DEFAULT_N / DEFAULT_W defaults, state_t (ST_EMPTY/ST_FULL), clog2_min1().
package mux_arb_pkg;

    localparam int DEFAULT_N = 4;
    localparam int DEFAULT_W = 8;

    // Output register occupancy; the encoding is exposed directly as out_valid.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    // Index width for n requesters, never below one bit so a vector is always legal.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        if (r < 1) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// rtl/mux_rr_arbiter_if.sv - requester and output handshake bundle for the arbiter
// Ports: req_valid/req_data/req_ready (N requesters), out_valid/out_data/out_src/out_ready.
// Modports: slave = arbiter side, master = requesters plus downstream consumer.
interface mux_rr_arbiter_if
    import mux_arb_pkg::*;
#(
    parameter int N = DEFAULT_N,
    parameter int W = DEFAULT_W
) ();

    localparam int IW = clog2_min1(N);

    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [IW-1:0]  out_src;
    logic           out_ready;

    modport slave (
        input  req_valid,
        input  req_data,
        output req_ready,
        output out_valid,
        output out_data,
        output out_src,
        input  out_ready
    );

    modport master (
        output req_valid,
        output req_data,
        input  req_ready,
        input  out_valid,
        input  out_data,
        input  out_src,
        output out_ready
    );

endinterface

// File: rtl/mux_rr_arbiter_picker.sv
// rtl/mux_rr_arbiter_picker.sv - combinational round-robin pick after last_grant
// Ports: req (N request bits), last_grant (index) -> any (some request set), g (granted index).
module rr_priority_picker #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_grant,
    output logic          any,
    output logic [IW-1:0] g
);

    // Rotate so the requester after last_grant lands at bit 0, take the lowest
    // set bit, then add the rotation back. Indices are wrapped by a single
    // conditional subtract, which also skips unused codes when N is not 2^k.
    always_comb begin
        logic [N-1:0] rot;
        int           s;
        int           off;
        rot = '0;
        s   = 0;
        off = 0;
        for (int i = 0; i < N; i++) begin
            s = int'(last_grant) + 1 + i;
            if (s >= N) begin
                s = s - N;
            end
            rot[i] = req[s];
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = i;
            end
        end
        s = int'(last_grant) + 1 + off;
        if (s >= N) begin
            s = s - N;
        end
        g   = IW'(s);
        any = |req;
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - round-robin arbiter feeding one registered N:1 mux path
// Ports: clk, rst_n (async, active-low), bus (mux_rr_arbiter_if.slave):
//   req_valid/req_data in, req_ready out (one-hot or zero),
//   out_valid/out_data/out_src out, out_ready in.
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int N = DEFAULT_N,
    parameter int W = DEFAULT_W
) (
    input logic            clk,
    input logic            rst_n,
    mux_rr_arbiter_if.slave bus
);

    localparam int IW = clog2_min1(N);

    state_t        state;
    logic [IW-1:0] last_grant;
    logic [IW-1:0] g;
    logic          any;
    logic          load;

    rr_priority_picker #(
        .N  (N),
        .IW (IW)
    ) u_picker (
        .req        (bus.req_valid),
        .last_grant (last_grant),
        .any        (any),
        .g          (g)
    );

    // rst_n gates load so nothing is acknowledged while reset is held.
    assign load = any && ((state == ST_EMPTY) || bus.out_ready) && rst_n;

    always_comb begin
        bus.req_ready = '0;
        if (load) begin
            bus.req_ready[g] = 1'b1;
        end
    end

    assign bus.out_valid = (state == ST_FULL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_EMPTY;
            bus.out_data <= '0;
            bus.out_src  <= '0;
            // Pointing at N-1 makes requester 0 the first candidate.
            last_grant   <= IW'(N - 1);
        end else if (load) begin
            // Covers both a fresh load and drain-plus-reload without a bubble.
            state        <= ST_FULL;
            bus.out_data <= bus.req_data[int'(g) * W +: W];
            bus.out_src  <= g;
            last_grant   <= g;
        end else if ((state == ST_FULL) && bus.out_ready) begin
            state <= ST_EMPTY;
        end
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb/tb_mux_rr_arbiter.sv - scoreboard bench for mux_rr_arbiter with directed and random traffic
module tb_mux_rr_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int IW = 2;

    logic clk;
    logic rst_n;

    mux_rr_arbiter_if #(.N(N), .W(W)) bus ();

    mux_rr_arbiter #(.N(N), .W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]  data;
        logic [IW-1:0] src;
    } exp_t;

    exp_t q[$];
    int   chk_cnt  = 0;
    int   pass_cnt = 0;
    int   m_lg     = N - 1;
    bit   m_full   = 1'b0;
    bit   cur_full = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference grant: walk forward from the previous winner, first valid wins.
    function automatic int model_pick(input logic [N-1:0] v);
        for (int k = 1; k <= N; k++) begin
            if (v[(m_lg + k) % N]) begin
                return (m_lg + k) % N;
            end
        end
        return -1;
    endfunction

    // One cycle of stimulus: drive after the falling edge, check req_ready,
    // then advance the model to what the next rising edge must do.
    task automatic step(input logic [N-1:0] v, input logic [N*W-1:0] d, input logic ordy);
        int           gi;
        bit           ld;
        logic [N-1:0] exp_rdy;
        exp_t         e;
        @(negedge clk);
        #1;
        bus.req_valid = v;
        bus.req_data  = d;
        bus.out_ready = ordy;
        cur_full      = m_full;
        gi            = model_pick(v);
        ld            = (gi >= 0) && (!m_full || ordy) && (rst_n == 1'b1);
        exp_rdy       = '0;
        if (ld) begin
            exp_rdy[gi] = 1'b1;
        end
        #1;
        chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
        if (ld) begin
            e.data = d[gi * W +: W];
            e.src  = IW'(gi);
            q.push_back(e);
            m_lg   = gi;
            m_full = 1'b1;
        end else if (ordy) begin
            m_full = 1'b0;
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_full   = 1'b0;
        cur_full = 1'b0;
        m_lg     = N - 1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        #1;
        bus.req_valid = '0;
        bus.out_ready = 1'b0;
        cur_full      = m_full;
        rst_n         = 1'b1;
    endtask

    // Monitor: the word on the output is compared with the scoreboard head
    // and retired when the consumer takes it on the coming edge.
    always begin
        @(negedge clk);
        #3;
        chk("out_valid", 32'(bus.out_valid), 32'(cur_full));
        if (cur_full) begin
            if (q.size() == 0) begin
                chk("scoreboard_empty", 32'(q.size()), 32'd1);
            end else begin
                chk("out_data", 32'(bus.out_data), 32'(q[0].data));
                chk("out_src", 32'(bus.out_src), 32'(q[0].src));
                if (bus.out_ready) begin
                    void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        rst_n         = 1'b0;
        bus.req_valid = '1;
        bus.req_data  = '0;
        bus.out_ready = 1'b1;

        // Held reset with every requester asking.
        for (int i = 0; i < 3; i++) step(4'b1111, 32'h33221100, 1'b1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        release_reset();

        // Full rotation, then sparse wrap from last_grant = 3.
        for (int i = 0; i < 8; i++) step(4'b1111, 32'h33221100, 1'b1);
        for (int i = 0; i < 6; i++) step(4'b1010, 32'h44332211, 1'b1);

        // Backpressure: A5 from requester 2 held for five stalled cycles.
        step(4'b0100, 32'h00A50000, 1'b1);
        for (int i = 0; i < 5; i++) step(4'b1111, 32'h0F0E0D0C, 1'b0);
        step(4'b1111, 32'h0F0E0D0C, 1'b1);

        // Idle pointer: grant 1, three idle cycles, then all valid.
        step(4'b0010, 32'h00007700, 1'b1);
        for (int i = 0; i < 3; i++) step(4'b0000, 32'h0, 1'b1);
        step(4'b1111, 32'hDDCCBBAA, 1'b1);

        // Async reset while FULL, between clock edges.
        step(4'b1000, 32'h99000000, 1'b1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("async_rst_ready", 32'(bus.req_ready), 32'd0);
        model_reset();
        step(4'b1111, 32'h0, 1'b1);
        release_reset();
        step(4'b1111, 32'h87654321, 1'b1);
        step(4'b1111, 32'h87654321, 1'b1);

        // Random traffic with mostly-ready consumer.
        for (int i = 0; i < 400; i++) begin
            step(N'($urandom), $urandom, ($urandom_range(0, 3) != 0));
        end

        for (int i = 0; i < 3; i++) step(4'b0000, 32'h0, 1'b1);
        chk("drained", 32'(q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/mux_rr_arbiter.md
# mux_rr_arbiter

Round-robin arbiter that shares one registered N:1 multiplexer path among N valid/ready requesters. It sits in front of any single-consumer datapath built from the combinational mux primitives: it decides which requester drives the shared mux select, captures the selected word into one output register, and presents it downstream with a valid/ready handshake. Arbitration is fair; no requester can be starved while it keeps its request asserted.

## Interface
- `N`, default 4: number of requesters, legal range 2..16.
- `W`, default 8: data width per requester.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  N  per-requester valid; bit i belongs to requester i.
- `req_data`  in  N*W  flattened data; requester i occupies bits [i*W +: W].
- `req_ready`  out  N  one-hot or zero; bit i high means requester i's word is accepted this cycle.
- `out_valid`  out  1  output register holds a word.
- `out_data`  out  W  captured word.
- `out_src`  out  $clog2(N)  index of the requester that supplied `out_data`.
- `out_ready`  in  1  downstream accepts the word this cycle.

## Operation
- Two states, encoded by `out_valid`: EMPTY (0) and FULL (1).
- `load` = any `req_valid` && (EMPTY || `out_ready`) && `rst_n`.
- Grant `g`: first index with `req_valid` set, searching `last_grant+1`, `last_grant+2`, … mod N. The search wraps from N-1 to 0.
- `req_ready[g]` = `load`. All other `req_ready` bits are 0. `req_ready` is combinational from `req_valid`, `out_valid`, `out_ready` and `last_grant`.
- On `load`:
  - `out_data` <= `req_data[g]`, `out_src` <= g, `last_grant` <= g.
  - Next state is FULL.
- On FULL && `out_ready` && !`load`: next state is EMPTY. `out_data` and `out_src` hold their values.
- On FULL && !`out_ready`: all registers hold. `req_ready` = 0, so the word stays stable under backpressure.
- `last_grant` changes only on `load`. When no requester is valid, the pointer does not advance.
- A requester may drop `req_valid` without a handshake. The arbiter makes no stickiness promise to requesters; the word is stable only on the output side.

## Timing
- Reset values (asynchronous, immediate on `rst_n` low):
  - `out_valid` = 0, `out_data` = 0, `out_src` = 0.
  - `last_grant` = N-1, so requester 0 has first priority after reset.
  - `req_ready` = 0 while `rst_n` = 0.
- Latency: a word accepted in cycle t appears with `out_valid` = 1 in cycle t+1.
- Throughput: one word per cycle when `out_ready` is held high. Back-to-back loads are allowed in the same cycle the output drains.
- Simultaneous drain and load: the register is overwritten with the new word and `out_valid` stays 1. No bubble.
- Reset mid-transfer: a held word is discarded and arbitration restarts at requester 0.
- N not a power of two: `out_src` never exceeds N-1, and the wrap skips unused codes.

## Structure
- Package `mux_arb_pkg`:
  - default `N` and `W` constants;
  - function `clog2_min1` (returns at least 1 bit for the index);
  - state encoding constants `ST_EMPTY` and `ST_FULL`.
- Sub-module `rr_priority_picker`, combinational:
  - inputs: N-bit request vector, `last_grant`;
  - outputs: `any`, index `g`.
  - Implemented as a rotate, then find-first, then un-rotate.
- Top level contains the output register, `last_grant` register and handshake logic.
- The data mux itself is an index select on `req_data`; no separate mux instance is required.

## Test plan
- Reset: hold `rst_n` = 0 with `req_valid` = 4'b1111 -> `req_ready` = 0 and `out_valid` = 0. After release, the first grant goes to requester 0 and `out_src` = 0 one cycle later.
- Full rotation: `req_valid` = 4'b1111, `out_ready` = 1, `req_data` = {8'h33, 8'h22, 8'h11, 8'h00} -> `out_src` sequence 0,1,2,3,0…, `out_data` 00,11,22,33, one per cycle.
- Sparse wrap: only requesters 1 and 3 valid, `last_grant` = 3 -> grants alternate 1,3,1,3. Requesters 0 and 2 never see `req_ready`.
- Backpressure: load 8'hA5 from requester 2, then hold `out_ready` = 0 for 5 cycles -> `out_valid` = 1, `out_data` = A5, `out_src` = 2 stable throughout and `req_ready` = 0. When `out_ready` = 1, the next word loads in the same cycle.
- Idle pointer: requester 1 granted, then all `req_valid` low for 3 cycles, then 4'b1111 -> next grant is 2. `out_valid` drops to 0 during the idle period.
- Async reset mid-hold: assert `rst_n` low between clock edges while FULL -> `out_valid` goes to 0 immediately. The next grant after release is requester 0.
